// File: rtl/hahalia_if.sv
// TinyTapeout tile pin bundle: dedicated inputs/outputs, bidir pins and tile enable.
// Pure wiring, no latency; no backpressure (pins are sampled/driven every cycle).
// The harness side uses master and the tile uses slave.
interface hahalia_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/hahalia.sv
// Half adder on ui_in[1:0] plus a 6-bit counter of carry cycles.
// SUM/CARRY are combinational; CNT updates one clk edge after sampling.
// No backpressure: every edge samples A, B, CLR and ena directly.
module hahalia (
  input  logic       clk,
  input  logic       rst_n,
  hahalia_if.slave   tt
);

  logic       a;
  logic       b;
  logic       clr;
  logic       sum;
  logic       carry;
  logic       inc_req;
  logic [5:0] cnt;
  logic [5:0] cnt_inc;
  logic [5:0] rc;
  logic       unused_pins;

  assign a   = tt.ui_in[0];
  assign b   = tt.ui_in[1];
  assign clr = tt.ui_in[2];

  assign sum     = a ^ b;
  assign carry   = a & b;
  assign inc_req = tt.ena & carry;

  // Ripple of half adders; with no request the chain passes cnt through unchanged.
  assign rc[0] = inc_req;
  for (genvar i = 0; i < 6; i++) begin : g_inc
    assign cnt_inc[i] = cnt[i] ^ rc[i];
    if (i < 5) begin : g_carry
      assign rc[i+1] = cnt[i] & rc[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 6'd0;
    end else if (tt.ena && clr) begin
      cnt <= 6'd0;
    end else begin
      cnt <= cnt_inc;
    end
  end

  assign tt.uo_out  = {cnt, carry, sum};
  assign tt.uio_out = 8'h00;
  assign tt.uio_oe  = 8'h00;

  assign unused_pins = &{1'b0, tt.ui_in[7:3], tt.uio_in};

endmodule

// File: tb/tb_hahalia.sv
// Directed bench for hahalia with an expected-value queue and a reference counter.
module tb_hahalia;

  logic clk;
  logic rst_n;

  hahalia_if tt ();

  hahalia dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tt    (tt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_err;
  logic [7:0] exp_q[$];

  logic       a_m;
  logic       b_m;
  logic       clr_m;
  logic       en_m;
  logic [5:0] cnt_m;

  task automatic jiggle();
    tt.ui_in[7:3] = 5'($urandom);
    tt.uio_in     = 8'($urandom);
  endtask

  task automatic drive(input logic a, input logic b, input logic clr, input logic en);
    a_m   = a;
    b_m   = b;
    clr_m = clr;
    en_m  = en;
    tt.ui_in[2:0] = {clr, b, a};
    tt.ena        = en;
    jiggle();
  endtask

  task automatic push_exp();
    logic [5:0] c;
    c = cnt_m;
    exp_q.push_back({c, a_m & b_m, a_m ^ b_m});
  endtask

  task automatic check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    n_cmp++;
    assert (tt.uo_out === e)
    else begin
      n_err++;
      $error("FAIL %s uo_out=%h expected=%h", tag, tt.uo_out, e);
    end
    n_cmp++;
    assert ({tt.uio_out, tt.uio_oe} === 16'h0000)
    else begin
      n_err++;
      $error("FAIL %s_static uio_out/uio_oe=%h expected=0000", tag, {tt.uio_out, tt.uio_oe});
    end
  endtask

  task automatic check_const(input string tag, input logic [7:0] e);
    n_cmp++;
    assert (tt.uo_out === e)
    else begin
      n_err++;
      $error("FAIL %s uo_out=%h expected=%h", tag, tt.uo_out, e);
    end
  endtask

  // One clock edge: update the reference model with the sampled inputs, then compare.
  task automatic clk_edge(input string tag);
    @(posedge clk);
    if (!rst_n)
      cnt_m = 6'd0;
    else if (en_m && clr_m)
      cnt_m = 6'd0;
    else if (en_m && a_m && b_m)
      cnt_m = cnt_m + 6'd1;
    #1;
    jiggle();
    #1;
    push_exp();
    check(tag);
  endtask

  task automatic edges(input int n, input string tag);
    for (int i = 0; i < n; i++) clk_edge(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cnt_m = 6'd0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    push_exp();
    check("reset");

    // Release between edges
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Truth table, no edges in between
    for (int ab = 0; ab < 4; ab++) begin
      drive(ab[0], ab[1], 1'b0, 1'b0);
      #1;
      push_exp();
      check($sformatf("truth_%0d%0d", ab[1], ab[0]));
    end

    // Gating
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    edges(6, "gate_no_carry");
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    edges(4, "gate_count");
    check_const("gate_cnt4", {6'd4, 2'b10});
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    edges(4, "gate_ena0");
    check_const("gate_hold4", {6'd4, 2'b10});

    // Truth table again with a nonzero count, still no edges
    for (int ab = 0; ab < 4; ab++) begin
      drive(ab[0], ab[1], 1'b0, 1'b1);
      #1;
      push_exp();
      check($sformatf("truth_cnt_%0d%0d", ab[1], ab[0]));
    end

    // Clear priority
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    edges(3, "to7");
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    clk_edge("clr_ena0");
    check_const("clr_ena0_hold7", {6'd7, 2'b10});
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    clk_edge("clr_ena1");
    check_const("clr_beats_inc", 8'h02);

    // Asynchronous reset mid-cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    edges(5, "to5");
    check_const("cnt5", {6'd5, 2'b10});
    #3;
    rst_n = 1'b0;
    cnt_m = 6'd0;
    #1;
    push_exp();
    check("async_reset");
    clk_edge("held_in_reset");
    rst_n = 1'b1;
    edges(3, "post_reset");
    check_const("post_reset_cnt3", {6'd3, 2'b10});

    // Wrap-around from reset
    rst_n = 1'b0;
    cnt_m = 6'd0;
    #1;
    rst_n = 1'b1;
    edges(63, "wrap_run");
    check_const("wrap_63", 8'hFE);
    clk_edge("wrap_edge");
    check_const("wrap_0", 8'h02);

    assert (exp_q.size() == 0)
    else $error("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
